// File: rtl/b02_pulse_window_counter.sv
// Counts single-cycle pulses over back-to-back windows of WIN cycles and hands
// each saturated total to a valid/ready consumer, flagging overwritten results.
module b02_pulse_window_counter #(
  parameter int WIN = 16,
  parameter int CW  = 5
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          enable,
  input  logic          u_in,
  input  logic          ready,
  input  logic          clr_lost,
  output logic [CW-1:0] count,
  output logic          valid,
  output logic          lost,
  output logic          busy
);

  localparam int CYW = (WIN > 2) ? $clog2(WIN) : 1;
  localparam logic [CYW-1:0] LAST = CYW'(WIN - 1);

  typedef enum logic {IDLE, COUNT} state_t;

  state_t         state_reg, state_next;
  logic [CW-1:0]  acc_reg, acc_next;
  logic [CYW-1:0] cyc_reg, cyc_next;
  logic [CW-1:0]  count_reg, count_next;
  logic           valid_reg, valid_next;
  logic           lost_reg, lost_next;
  logic           close;
  logic [CW:0]    sum_ext;
  logic [CW-1:0]  acc_sat;

  // One extra bit catches the carry so the total clamps instead of wrapping.
  assign sum_ext = {1'b0, acc_reg} + {{CW{1'b0}}, u_in};
  assign acc_sat = sum_ext[CW] ? {CW{1'b1}} : sum_ext[CW-1:0];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      acc_reg   <= '0;
      cyc_reg   <= '0;
      count_reg <= '0;
      valid_reg <= 1'b0;
      lost_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      acc_reg   <= acc_next;
      cyc_reg   <= cyc_next;
      count_reg <= count_next;
      valid_reg <= valid_next;
      lost_reg  <= lost_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    acc_next   = acc_reg;
    cyc_next   = cyc_reg;
    count_next = count_reg;
    valid_next = valid_reg;
    lost_next  = lost_reg;
    close      = 1'b0;

    case (state_reg)
      IDLE: begin
        if (enable) begin
          state_next = COUNT;
          acc_next   = '0;
          cyc_next   = '0;
        end
      end
      COUNT: begin
        if (!enable) begin
          state_next = IDLE;
          acc_next   = '0;
          cyc_next   = '0;
        end else if (cyc_reg == LAST) begin
          // Closing edge: its own pulse is included and the next window starts
          // on the following edge without a gap.
          close      = 1'b1;
          count_next = acc_sat;
          acc_next   = '0;
          cyc_next   = '0;
        end else begin
          acc_next = acc_sat;
          cyc_next = cyc_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    if (close) begin
      valid_next = 1'b1;
    end else if (valid_reg && ready) begin
      valid_next = 1'b0;
    end

    // Setting has priority over clearing when both land on the same edge.
    if (close && valid_reg && !ready) begin
      lost_next = 1'b1;
    end else if (clr_lost) begin
      lost_next = 1'b0;
    end
  end

  assign count = count_reg;
  assign valid = valid_reg;
  assign lost  = lost_reg;
  assign busy  = (state_reg == COUNT);

endmodule
